// File: rtl/proj_gfm_collector_pkg.sv
// proj_pkg: shared widths, collector constants and the buffered fragment record type
package proj_pkg;
  localparam int FM_EXTENDER_FRAG_LEN_BITS = 32;
  localparam int EXTENDER_OUT_PART_LEN = 8;
  localparam int FRAG_LEN = 16;
  localparam int GENOME_LEN = 1024;
  localparam int INDICE_LEN = 10;
  localparam int SIGNED_INDICE_LEN = INDICE_LEN + 1;
  localparam int COLLECTOR_FIFO_DEPTH = 4;
  localparam int COLLECTOR_PARTS = FM_EXTENDER_FRAG_LEN_BITS / EXTENDER_OUT_PART_LEN;
  typedef struct packed {
    logic [INDICE_LEN-1:0] index;
    logic [FM_EXTENDER_FRAG_LEN_BITS-1:0] fragment;
    logic clamped;
  } gfm_rec_t;
endpackage

// File: rtl/proj_gfm_collector_fifo.sv
// proj_sync_fifo: registered-storage FIFO, head on dout (zero when empty); ports clk, rst_n, push/din, pop/dout, full, empty
module proj_sync_fifo #(
  parameter int W = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign full = cnt == (AW+1)'(D);
  assign empty = cnt == '0;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/proj_gfm_collector.sv
// proj_gfm_collector: reassembles extender parts into clamped fragment records queued to a valid/ready output; ports clk, rst_n, in_valid/in_index/in_gfm, out_valid/out_ready/out_index/out_fragment/out_clamped, overflow, idx_mismatch
module proj_gfm_collector
  import proj_pkg::*;
#(
  parameter int FRAG_LEN_BITS = FM_EXTENDER_FRAG_LEN_BITS,
  parameter int FRAG_PART = EXTENDER_OUT_PART_LEN,
  parameter int FRAG_SIZE = FRAG_LEN,
  parameter int GENOME_LEN = proj_pkg::GENOME_LEN,
  parameter int INDICE_LEN = proj_pkg::INDICE_LEN,
  parameter int SIGNED_INDICE_LEN = proj_pkg::SIGNED_INDICE_LEN,
  parameter int FIFO_DEPTH = COLLECTOR_FIFO_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic [SIGNED_INDICE_LEN-1:0] in_index,
  input  logic [FRAG_PART-1:0]         in_gfm,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INDICE_LEN-1:0]        out_index,
  output logic [FRAG_LEN_BITS-1:0]     out_fragment,
  output logic                         out_clamped,
  output logic                         overflow,
  output logic                         idx_mismatch
);
  localparam int PARTS = FRAG_LEN_BITS / FRAG_PART;
  localparam int KW = PARTS > 1 ? $clog2(PARTS) : 1;
  localparam int MAX_START = GENOME_LEN - FRAG_SIZE;
  logic [KW-1:0] k;
  logic [FRAG_LEN_BITS-1:0] asm_q, frag_now;
  logic [SIGNED_INDICE_LEN-1:0] cap, idx_now;
  logic last, neg, over, full, empty, pop;
  gfm_rec_t rec, head;
  assign last = in_valid && k == KW'(PARTS - 1);
  assign idx_now = k == '0 ? in_index : cap;
  assign neg = idx_now[SIGNED_INDICE_LEN-1];
  assign over = !neg && idx_now > SIGNED_INDICE_LEN'(MAX_START);
  always_comb begin
    frag_now = asm_q;
    frag_now[FRAG_PART*k +: FRAG_PART] = in_gfm;
  end
  assign rec.index = neg ? '0 : over ? INDICE_LEN'(MAX_START) : idx_now[INDICE_LEN-1:0];
  assign rec.fragment = frag_now;
  assign rec.clamped = neg || over;
  assign pop = out_valid && out_ready;
  always_ff @(posedge clk)
    if (!rst_n) begin
      k <= '0;
      asm_q <= '0;
      cap <= '0;
      overflow <= 1'b0;
      idx_mismatch <= 1'b0;
    end else begin
      if (in_valid) begin
        k <= last ? '0 : k + 1'b1;
        asm_q <= frag_now;
        if (k == '0) cap <= in_index;
        else if (in_index != cap) idx_mismatch <= 1'b1;
      end
      if (last && full && !pop) overflow <= 1'b1;
    end
  proj_sync_fifo #(.W($bits(gfm_rec_t)), .D(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(last),
    .din(rec),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  assign out_valid = !empty;
  assign out_index = head.index;
  assign out_fragment = head.fragment;
  assign out_clamped = head.clamped;
endmodule
